// File: rtl/cell_truth_checker.sv
// cell_truth_checker: walks all 16 input vectors of a 4-input cell, samples its
// synchronized output after a settle delay and compares it against a truth table.
module cell_truth_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] TRUTH         = 16'h111F
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Y,
    output logic       A1,
    output logic       A2,
    output logic       B1,
    output logic       B2,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERR_COUNT,
    output logic [3:0] FIRST_FAIL,
    output logic       FAIL_VALID
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, FIN} stateT;
    stateT state, nextState;
    logic [1:0] ySync;
    logic [3:0] vec;
    logic [3:0] drive;
    logic [8:0] waitCnt;
    logic       mismatch;

    assign mismatch = ySync[1] != TRUTH[vec];
    assign {A1, A2, B1, B2} = drive;
    assign BUSY = state == APPLY || state == WAIT || state == SAMPLE;
    assign DONE = state == FIN;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = START ? APPLY : IDLE;
            APPLY:   nextState = WAIT;
            WAIT:    nextState = (waitCnt == 9'd1) ? SAMPLE : WAIT;
            SAMPLE:  nextState = (vec == 4'd15) ? FIN : APPLY;
            default: nextState = IDLE;
        endcase
        if (ABORT) nextState = IDLE;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ySync      <= '0;
            vec        <= '0;
            drive      <= '0;
            waitCnt    <= '0;
            ERR_COUNT  <= '0;
            FIRST_FAIL <= '0;
            FAIL_VALID <= 1'b0;
            PASS       <= 1'b0;
        end else begin
            ySync <= {ySync[0], Y};
            // Abort keeps the partial error results but drops the cell inputs and verdict.
            if (ABORT) begin
                if (state != IDLE) begin
                    drive <= '0;
                    PASS  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: if (START) begin
                        vec        <= '0;
                        ERR_COUNT  <= '0;
                        FIRST_FAIL <= '0;
                        FAIL_VALID <= 1'b0;
                        PASS       <= 1'b0;
                    end
                    APPLY: begin
                        drive   <= vec;
                        waitCnt <= 9'(SETTLE_CYCLES + 2);
                    end
                    WAIT: waitCnt <= waitCnt - 9'd1;
                    SAMPLE: begin
                        if (mismatch) begin
                            ERR_COUNT <= ERR_COUNT + 5'd1;
                            if (!FAIL_VALID) begin
                                FIRST_FAIL <= vec;
                                FAIL_VALID <= 1'b1;
                            end
                        end
                        // Verdict is settled here so it is valid during the DONE cycle.
                        if (vec == 4'd15) PASS <= ERR_COUNT == 5'd0 && !mismatch;
                        else vec <= vec + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cell_truth_checker.sv
// tb_cell_truth_checker: table-driven and randomized runs of two checker instances
// (default settle and zero settle) against a behavioural OAI22 cell model.
module tb_cell_truth_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, start, abort, sel;
    logic a1, a2, b1, b2, busy, done, pass, failValid, y;
    logic [4:0] errCount;
    logic [3:0] firstFail;
    logic a1z, a2z, b1z, b2z, busyz, donez, passz, failValidz, yz;
    logic [4:0] errCountz;
    logic [3:0] firstFailz;
    int yMode;
    logic [15:0] faultMask;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int mode;
        logic [15:0] mask;
        int err;
        int first;
        int fv;
    } vecT;
    vecT table_[6];

    function automatic logic cellY(input logic [3:0] v);
        return !((v[3] | v[2]) & (v[1] | v[0]));
    endfunction

    function automatic logic yFor(input logic [3:0] v, input int mode, input logic [15:0] mask);
        return mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : cellY(v) ^ mask[v];
    endfunction

    assign y  = yFor({a1, a2, b1, b2}, yMode, faultMask);
    assign yz = yFor({a1z, a2z, b1z, b2z}, yMode, faultMask);

    cell_truth_checker dut (
        .CLK(clk), .RESETN(resetn), .START(start && !sel), .ABORT(abort), .Y(y),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_COUNT(errCount), .FIRST_FAIL(firstFail), .FAIL_VALID(failValid)
    );

    cell_truth_checker #(.SETTLE_CYCLES(0)) dutz (
        .CLK(clk), .RESETN(resetn), .START(start && sel), .ABORT(abort), .Y(yz),
        .A1(a1z), .A2(a2z), .B1(b1z), .B2(b2z), .BUSY(busyz), .DONE(donez), .PASS(passz),
        .ERR_COUNT(errCountz), .FIRST_FAIL(firstFailz), .FAIL_VALID(failValidz)
    );

    logic [3:0] curA, curFirst;
    logic [4:0] curErr;
    logic curBusy, curDone, curPass, curFv;
    always_comb begin
        curA     = sel ? {a1z, a2z, b1z, b2z} : {a1, a2, b1, b2};
        curFirst = sel ? firstFailz : firstFail;
        curErr   = sel ? errCountz : errCount;
        curBusy  = sel ? busyz : busy;
        curDone  = sel ? donez : done;
        curPass  = sel ? passz : pass;
        curFv    = sel ? failValidz : failValid;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic refModel(input int nVec, output int e, output int f, output int fv);
        e = 0; f = 0; fv = 0;
        for (int v = 0; v < nVec; v++)
            if (yFor(4'(v), yMode, faultMask) != cellY(4'(v))) begin
                e++;
                if (fv == 0) begin f = v; fv = 1; end
            end
    endtask

    task automatic doRun(input int s, input bit hammer, input int expErr, input int expFirst, input int expFv);
        int k = 0;
        int total = 16 * (s + 4) + 1;
        int doneAt = -1;
        int doneCnt = 0;
        bit seqOk = 1'b1;
        bit busyOk = 1'b1;
        @(negedge clk);
        start = 1'b1;
        while (k < total + 20 && doneAt < 0) begin
            @(negedge clk);
            k++;
            if (!hammer) start = 1'b0;
            if (k >= 2 && int'(curA) != ((k - 2) / (s + 4) > 15 ? 15 : (k - 2) / (s + 4))) seqOk = 1'b0;
            if (curBusy != (k < total)) busyOk = 1'b0;
            if (curDone) begin doneCnt++; doneAt = k; end
        end
        start = 1'b0;
        chk("done_cycle", doneAt, total);
        chk("vector_sequence", int'(seqOk), 1);
        chk("busy_window", int'(busyOk), 1);
        chk("err_count", int'(curErr), expErr);
        chk("fail_valid", int'(curFv), expFv);
        if (expFv != 0) chk("first_fail", int'(curFirst), expFirst);
        chk("pass", int'(curPass), int'(expErr == 0));
        repeat (6) begin
            @(negedge clk);
            if (curDone) doneCnt++;
        end
        chk("done_count", doneCnt, 1);
        chk("result_hold", int'(curErr), expErr);
    endtask

    initial begin
        int e, f, fv, k, doneSeen;
        table_[0] = '{0, 16'h0000, 0, 0, 0};
        table_[1] = '{1, 16'h0000, 9, 5, 1};
        table_[2] = '{2, 16'h0000, 7, 0, 1};
        table_[3] = '{0, 16'h8000, 1, 15, 1};
        table_[4] = '{0, 16'h0001, 1, 0, 1};
        table_[5] = '{0, 16'h0F00, 4, 8, 1};
        resetn = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; yMode = 0; faultMask = '0;
        #1;
        chk("reset_state", int'({a1, a2, b1, b2, busy, done, pass, errCount, firstFail, failValid}), 0);
        chk("reset_state_z", int'({a1z, a2z, b1z, b2z, busyz, donez, passz, errCountz, firstFailz, failValidz}), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        foreach (table_[i]) begin
            yMode = table_[i].mode;
            faultMask = table_[i].mask;
            doRun(2, 1'b0, table_[i].err, table_[i].first, table_[i].fv);
        end

        for (int r = 0; r < 4; r++) begin
            yMode = 0;
            faultMask = 16'($urandom);
            sel = r[0];
            refModel(16, e, f, fv);
            doRun(sel ? 0 : 2, r >= 2, e, f, fv);
        end
        sel = 1'b0;

        // Abort mid-run: partial results hold, no DONE, cell inputs drop to zero.
        yMode = 1; faultMask = '0;
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        refModel(6, e, f, fv);
        chk("abort_busy", int'(busy), 0);
        chk("abort_drive", int'({a1, a2, b1, b2}), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(errCount), e);
        chk("abort_first", int'(firstFail), f);
        doneSeen = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        chk("abort_no_done", doneSeen, 0);
        chk("abort_err_hold", int'(errCount), e);
        refModel(16, e, f, fv);
        doRun(2, 1'b0, e, f, fv);

        // Asynchronous reset in the middle of a WAIT phase.
        yMode = 2;
        @(negedge clk);
        start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_err", int'(errCount), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset", int'({a1, a2, b1, b2, busy, done, pass, errCount, firstFail, failValid}), 0);
        @(negedge clk);
        resetn = 1'b1;
        sel = 1'b1; yMode = 0; faultMask = '0;
        doRun(0, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
